// File: rtl/hazard_ctrl_param_if.sv
// Hazard-controller bundle: pipeline hazard inputs and the stall/flush controls returned to the pipe.
interface hazard_ctrl_param_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic             idex_mem_read;
    logic [AW-1:0]    idex_rt;
    logic [AW-1:0]    ifid_rs;
    logic [AW-1:0]    ifid_rt;
    logic             ifid_uses_rt;
    logic             id_branch;
    logic             mc_start;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_hold;
    logic             ctrl_bubble;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: presents hazard sources, consumes stall controls
    modport master (
        output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, id_branch, mc_start,
        input  pc_hold, ifid_hold, ifid_flush, idex_hold, ctrl_bubble, state_o, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, id_branch, mc_start,
        output pc_hold, ifid_hold, ifid_flush, idex_hold, ctrl_bubble, state_o, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Parametrised 5-stage pipeline hazard controller: load-use, ID-branch and multicycle-EX stalls,
// sequenced by a timed FSM, plus a saturating stall-cycle counter.
module hazard_ctrl_param #(
    parameter int unsigned AW           = 5,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned BRANCH_STALL = 2,
    parameter int unsigned MC_CYCLES    = 4,
    parameter int unsigned ZERO_EXEMPT  = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_param_if.slave hz
);
    localparam int unsigned MAX_LB    = (LOAD_STALL > BRANCH_STALL) ? LOAD_STALL : BRANCH_STALL;
    localparam int unsigned MAX_STALL = (MAX_LB > MC_CYCLES) ? MAX_LB : MC_CYCLES;
    localparam int unsigned CW        = ($clog2(MAX_STALL) < 1) ? 1 : $clog2(MAX_STALL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LD   = 2'd1,
        ST_BR   = 2'd2,
        ST_MC   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_c;
    logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_hold_c, ctrl_bubble_c;

    // Load-use detect; register 0 optionally exempt since it never carries loaded data
    always_comb begin
        lu_c = hz.idex_mem_read
               & ((hz.idex_rt == hz.ifid_rs) | (hz.ifid_uses_rt & (hz.idex_rt == hz.ifid_rt)))
               & ~((ZERO_EXEMPT != 0) & (hz.idex_rt == '0));
    end

    // Next state and controls: Mealy in IDLE, Moore in timed states, all forced low in reset
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_hold_c   = 1'b0;
        ctrl_bubble_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hz.mc_start && (MC_CYCLES > 1)) begin
                    pc_hold_c   = 1'b1;
                    ifid_hold_c = 1'b1;
                    idex_hold_c = 1'b1;
                    if (MC_CYCLES > 2) begin
                        state_d = ST_MC;
                        cnt_d   = CW'(MC_CYCLES - 3);
                    end
                end else if (lu_c) begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    ctrl_bubble_c = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_LD;
                        cnt_d   = CW'(LOAD_STALL - 2);
                    end
                end else if (hz.id_branch) begin
                    pc_hold_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (BRANCH_STALL > 1) begin
                        state_d = ST_BR;
                        cnt_d   = CW'(BRANCH_STALL - 2);
                    end
                end
            end
            ST_LD: begin
                pc_hold_c     = 1'b1;
                ifid_hold_c   = 1'b1;
                ctrl_bubble_c = 1'b1;
            end
            ST_BR: begin
                pc_hold_c    = 1'b1;
                ifid_flush_c = 1'b1;
            end
            ST_MC: begin
                pc_hold_c   = 1'b1;
                ifid_hold_c = 1'b1;
                idex_hold_c = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timed states count down and hand back to IDLE, where the held ID instruction is re-checked
        if (state_q != ST_IDLE) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (reset) begin
            pc_hold_c     = 1'b0;
            ifid_hold_c   = 1'b0;
            ifid_flush_c  = 1'b0;
            idex_hold_c   = 1'b0;
            ctrl_bubble_c = 1'b0;
        end
    end

    // Saturating count of cycles with the PC held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, timer and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_hold     = pc_hold_c;
    assign hz.ifid_hold   = ifid_hold_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_hold   = idex_hold_c;
    assign hz.ctrl_bubble = ctrl_bubble_c;
    assign hz.state_o     = state_q;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule
